// File: rtl/mpu_unary_seq.sv
// Sequential element-wise unary unit (negate / abs / pass / x2) over a SIZE x SIZE signed matrix, LANES elements per beat.
// Optional saturation with sticky overflow is enabled by defining MPU_UNARY_SAT_EN; otherwise results wrap and overflow is 0.
module mpu_unary_seq #(
  parameter int DATA_W = 8,
  parameter int SIZE   = 5,
  parameter int LANES  = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [1:0]                    op,
  input  logic [SIZE*SIZE*DATA_W-1:0]   matrix_a,
  output logic [SIZE*SIZE*DATA_W-1:0]   result,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  localparam int NUM   = SIZE * SIZE;
  localparam int BEATS = (NUM + LANES - 1) / LANES;
  localparam int IDX_W = $clog2(BEATS * LANES + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  typedef enum logic [1:0] {OP_NEG = 2'b00, OP_ABS = 2'b01, OP_PASS = 2'b10, OP_X2 = 2'b11} op_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     idx;
  op_t                  op_q;
  logic [NUM*DATA_W-1:0] a_q;

  int                   lane_k   [LANES];
  logic [DATA_W-1:0]    lane_val [LANES];
  logic [LANES-1:0]     lane_wr;
  logic                 last_beat;

  // Two's-complement wrapping result of one element.
  function automatic logic [DATA_W-1:0] wrap_op(input op_t f, input logic [DATA_W-1:0] x);
    case (f)
      OP_NEG:  return -x;
      OP_ABS:  return x[DATA_W-1] ? -x : x;
      OP_PASS: return x;
      default: return {x[DATA_W-2:0], 1'b0};
    endcase
  endfunction

`ifdef MPU_UNARY_SAT_EN
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};

  logic [LANES-1:0] lane_ovf;

  // MIN has no positive counterpart; x2 overflows when the top two bits disagree.
  function automatic logic elem_ovf(input op_t f, input logic [DATA_W-1:0] x);
    case (f)
      OP_NEG, OP_ABS: return x == MIN_V;
      OP_PASS:        return 1'b0;
      default:        return x[DATA_W-1] ^ x[DATA_W-2];
    endcase
  endfunction
`endif

  always_comb begin
    // NOTE: every variable gets a value on every path through always_comb, otherwise synthesis infers a latch.
    for (int l = 0; l < LANES; l++) begin
      lane_k[l]  = int'(idx) + l;
      lane_wr[l] = lane_k[l] < NUM;
`ifdef MPU_UNARY_SAT_EN
      lane_ovf[l] = elem_ovf(op_q, a_q[(lane_wr[l] ? lane_k[l] : 0)*DATA_W +: DATA_W]);
      if (lane_ovf[l])
        lane_val[l] = (op_q == OP_X2 && a_q[(lane_wr[l] ? lane_k[l] : 0)*DATA_W + DATA_W-1]) ? MIN_V : MAX_V;
      else
        lane_val[l] = wrap_op(op_q, a_q[(lane_wr[l] ? lane_k[l] : 0)*DATA_W +: DATA_W]);
`else
      lane_val[l] = wrap_op(op_q, a_q[(lane_wr[l] ? lane_k[l] : 0)*DATA_W +: DATA_W]);
`endif
    end
    last_beat = int'(idx) + LANES >= NUM;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_beat) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: operand registers carry no reset; they are always reloaded on accept before being read.
  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      a_q  <= matrix_a;
      op_q <= op_t'(op);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        idx <= '0;
      end else if (state == RUN) begin
        for (int l = 0; l < LANES; l++)
          if (lane_wr[l]) result[lane_k[l]*DATA_W +: DATA_W] <= lane_val[l];
        idx <= idx + IDX_W'(LANES);
      end
    end
  end

`ifdef MPU_UNARY_SAT_EN
  always_ff @(posedge clock) begin
    if (reset)
      overflow <= 1'b0;
    else if (state == IDLE && start)
      overflow <= 1'b0;
    else if (state == RUN && |(lane_ovf & lane_wr))
      overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mpu_unary_seq.sv
// Self-checking bench for mpu_unary_seq: default 5-lane instance plus a 3-lane instance, scoreboard of expected results.
module tb_mpu_unary_seq;

  localparam int DW  = 8;
  localparam int NUM = 25;
  localparam int VW  = NUM * DW;

  logic          clock = 1'b0;
  logic          reset;
  logic          start5, start3;
  logic [1:0]    op5, op3;
  logic [VW-1:0] mat5, mat3, res5, res3;
  logic          busy5, busy3, done5, done3, ovf5, ovf3;

  always #5 clock = ~clock;

  mpu_unary_seq dut5 (
    .clock(clock), .reset(reset), .start(start5), .op(op5), .matrix_a(mat5),
    .result(res5), .busy(busy5), .done(done5), .overflow(ovf5)
  );

  mpu_unary_seq #(.DATA_W(8), .SIZE(5), .LANES(3)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .op(op3), .matrix_a(mat3),
    .result(res3), .busy(busy3), .done(done3), .overflow(ovf3)
  );

  typedef struct {
    logic [VW-1:0] res;
    logic          ovf;
  } exp_t;

  exp_t q5[$];
  exp_t q3[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_elem(input logic [1:0] f, input logic [DW-1:0] a, inout bit any_ovf);
    int x = $signed(a);
    int r;
    case (f)
      2'b00:   r = -x;
      2'b01:   r = (x < 0) ? -x : x;
      2'b10:   r = x;
      default: r = 2 * x;
    endcase
`ifdef MPU_UNARY_SAT_EN
    if (r > 127) begin r = 127; any_ovf = 1'b1; end
    else if (r < -128) begin r = -128; any_ovf = 1'b1; end
`endif
    return DW'(r);
  endfunction

  function automatic exp_t model(input logic [1:0] f, input logic [VW-1:0] m);
    exp_t e;
    bit   o = 1'b0;
    for (int k = 0; k < NUM; k++) e.res[k*DW +: DW] = model_elem(f, m[k*DW +: DW], o);
    e.ovf = o;
    return e;
  endfunction

  function automatic logic [VW-1:0] rand_mat();
    logic [VW-1:0] m;
    for (int i = 0; i < NUM; i++) m[i*DW +: DW] = DW'($urandom);
    return m;
  endfunction

  // Drives one start pulse, records the expectation, then scrambles op/matrix to prove they were captured.
  task automatic launch(input bit sel, input logic [1:0] f, input logic [VW-1:0] m);
    @(negedge clock);
    if (sel) begin op3 = f; mat3 = m; start3 = 1'b1; q3.push_back(model(f, m)); end
    else     begin op5 = f; mat5 = m; start5 = 1'b1; q5.push_back(model(f, m)); end
    @(negedge clock);
    start3 = 1'b0;
    start5 = 1'b0;
    if (sel) begin op3 = ~f; mat3 = ~m; end
    else     begin op5 = ~f; mat5 = ~m; end
  endtask

  task automatic await_done(input bit sel, input string tag, input int exp_busy);
    int   busy_cnt = 0;
    int   cyc      = 0;
    exp_t e;
    while (!(sel ? done3 : done5) && cyc < 60) begin
      if (sel ? busy3 : busy5) busy_cnt++;
      @(negedge clock);
      cyc++;
    end
    check({tag, "_done"}, VW'(sel ? done3 : done5), VW'(1));
    check({tag, "_busy_cycles"}, VW'(busy_cnt), VW'(exp_busy));
    check({tag, "_busy_in_done"}, VW'(sel ? busy3 : busy5), VW'(0));
    if ((sel ? q3.size() : q5.size()) == 0) begin
      total++;
      bad++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      if (sel) e = q3.pop_front(); else e = q5.pop_front();
      check({tag, "_result"}, sel ? res3 : res5, e.res);
      check({tag, "_overflow"}, VW'(sel ? ovf3 : ovf5), VW'(e.ovf));
      @(negedge clock);
      check({tag, "_done_pulse"}, VW'(sel ? done3 : done5), VW'(0));
      check({tag, "_held"}, sel ? res3 : res5, e.res);
    end
  endtask

  initial begin
    logic [VW-1:0] m;
    bit            saw_done;

    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] m;
    bit            saw_done;

    reset = 1'b1; start5 = 1'b0; start3 = 1'b0;
    op5 = '0; op3 = '0; mat5 = '0; mat3 = '0;
    repeat (2) @(negedge clock);
    check("rst_result5", res5, '0);
    check("rst_result3", res3, '0);
    check("rst_busy", VW'({busy5, busy3}), VW'(0));
    check("rst_done", VW'({done5, done3}), VW'(0));
    check("rst_ovf", VW'({ovf5, ovf3}), VW'(0));
    reset = 1'b0;

    // Negate a ramp: A[k] = k-12.
    for (int k = 0; k < NUM; k++) m[k*DW +: DW] = DW'(k - 12);
    launch(1'b0, 2'b00, m);
    await_done(1'b0, "neg_ramp", 5);

    // Abs of MIN everywhere.
    m = {NUM{8'h80}};
    launch(1'b0, 2'b01, m);
    await_done(1'b0, "abs_min", 5);

    // x2 around the range limits.
    m = '0;
    m[0*DW +: DW] = 8'd100;
    m[1*DW +: DW] = 8'h9C;
    m[2*DW +: DW] = 8'd63;
    launch(1'b0, 2'b11, m);
    await_done(1'b0, "x2_edges", 5);

    // Random operands and ops on the 5-lane unit.
    for (int i = 0; i < 4; i++) begin
      launch(1'b0, 2'(i), rand_mat());
      await_done(1'b0, "rand5", 5);
    end

    // Three lanes: 9 beats, last beat has two unused lanes.
    launch(1'b1, 2'b10, rand_mat());
    await_done(1'b1, "pass3", 9);
    launch(1'b1, 2'b00, rand_mat());
    await_done(1'b1, "neg3", 9);

    // A second start during RUN must be ignored.
    launch(1'b0, 2'b01, rand_mat());
    op5 = 2'b11;
    mat5 = rand_mat();
    start5 = 1'b1;
    @(negedge clock);
    start5 = 1'b0;
    await_done(1'b0, "ignored_start", 4);
    repeat (3) @(negedge clock);
    check("ignored_start_idle", VW'(busy5), VW'(0));

    // Reset at the second RUN beat aborts the operation.
    launch(1'b0, 2'b00, rand_mat());
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy", VW'(busy5), VW'(0));
    check("abort_result", res5, '0);
    reset = 1'b0;
    void'(q5.pop_back());
    saw_done = 1'b0;
    repeat (10) begin
      if (done5) saw_done = 1'b1;
      @(negedge clock);
    end
    check("abort_no_done", VW'(saw_done), VW'(0));
    launch(1'b0, 2'b11, rand_mat());
    await_done(1'b0, "after_abort", 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
